// File: rtl/mem_loader.sv
// mem_loader: streams a block of words from a valid-only source into a memory.
// It can then read the block back to compare checksums. It finishes by loading
// the base address into the A register and pulsing done.
module mem_loader #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              verify_en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    output logic              reg_m_en,
    output logic              reg_a_en,
    output logic              reg_d_en,
    input  logic [DATA_W-1:0] reg_m_out
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DRAIN  = 3'd2,
        VERIFY = 3'd3,
        SET_A  = 3'd4,
        FIN    = 3'd5
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_next;

    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W:0]     r_count;
    logic                r_verify;
    // Word index: words accepted while loading, words read back while verifying.
    logic [ADDR_W:0]     r_offset;
    logic [DATA_W-1:0]   r_sum;
    logic [DATA_W-1:0]   r_rsum;

    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_m_en;
    logic                r_a_en;
    logic                r_done;
    logic                r_error;

    logic                w_handshake;
    logic [ADDR_W:0]     w_count_m1;
    logic                w_last_word;
    logic                w_last_read;
    logic [DATA_W-1:0]   w_rsum_next;

    assign w_handshake = (r_state == LOAD) && in_valid;
    assign w_count_m1  = r_count - CNT_ONE;
    assign w_last_word = w_handshake && (r_offset == w_count_m1);
    assign w_last_read = (r_state == VERIFY) && (r_offset == w_count_m1);
    assign w_rsum_next = r_rsum + reg_m_out;

    assign in_ready = (r_state == LOAD);
    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign error    = r_error;
    assign addr     = r_addr;
    assign data_in  = r_data;
    assign reg_m_en = r_m_en;
    assign reg_a_en = r_a_en;
    assign reg_d_en = 1'b0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        w_next = LOAD;
                    end else begin
                        w_next = SET_A;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            LOAD: begin
                if (w_last_word) begin
                    w_next = DRAIN;
                end else begin
                    w_next = LOAD;
                end
            end
            DRAIN: begin
                if (r_verify) begin
                    w_next = VERIFY;
                end else begin
                    w_next = SET_A;
                end
            end
            VERIFY: begin
                if (w_last_read) begin
                    w_next = SET_A;
                end else begin
                    w_next = VERIFY;
                end
            end
            SET_A:   w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath and registered outputs; strobes are single-cycle unless re-armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base   <= '0;
            r_count  <= '0;
            r_verify <= 1'b0;
            r_offset <= '0;
            r_sum    <= '0;
            r_rsum   <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_m_en   <= 1'b0;
            r_a_en   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_m_en <= 1'b0;
            r_a_en <= 1'b0;
            r_done <= (w_next == FIN);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base   <= base_addr;
                        r_count  <= word_count;
                        r_verify <= verify_en;
                        r_offset <= '0;
                        r_sum    <= '0;
                        r_rsum   <= '0;
                        r_error  <= 1'b0;
                        // An empty transfer goes straight to the A-register load.
                        if (word_count == '0) begin
                            r_data <= DATA_W'(base_addr);
                            r_a_en <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (w_handshake) begin
                        r_addr   <= r_base + r_offset[ADDR_W-1:0];
                        r_data   <= in_data;
                        r_m_en   <= 1'b1;
                        r_sum    <= r_sum + in_data;
                        r_offset <= r_offset + CNT_ONE;
                    end
                end
                DRAIN: begin
                    // The last write lands at the end of this cycle, so the
                    // readback of the first address can start right after it.
                    r_offset <= '0;
                    if (r_verify) begin
                        r_addr <= r_base;
                    end else begin
                        r_data <= DATA_W'(r_base);
                        r_a_en <= 1'b1;
                    end
                end
                VERIFY: begin
                    r_rsum   <= w_rsum_next;
                    r_offset <= r_offset + CNT_ONE;
                    r_addr   <= r_base + r_offset[ADDR_W-1:0] + ADDR_ONE;
                    if (w_last_read) begin
                        r_error <= (w_rsum_next != r_sum);
                        r_data  <= DATA_W'(r_base);
                        r_a_en  <= 1'b1;
                    end
                end
                SET_A: begin
                    r_offset <= r_offset;
                end
                FIN: begin
                    r_offset <= r_offset;
                end
                default: begin
                    r_offset <= '0;
                end
            endcase
        end
    end

endmodule
